// File: rtl/wb_cache.sv
// ============================================================================
// Module   : wb_cache
// Purpose  : Direct-mapped, write-through, no-write-allocate Wishbone cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_cache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        S_CYC,
    input  logic        S_STB,
    input  logic        S_WE,
    input  logic [31:0] S_ADR,
    input  logic [31:0] S_DAT_O,
    input  logic [2:0]  S_CTI_O,
    output logic [31:0] S_DAT_I,
    output logic        S_ACK,
    output logic        S_ERR,
    output logic        S_RTY,
    output logic        M_CYC,
    output logic        M_STB,
    output logic        M_WE,
    output logic [31:0] M_ADR,
    output logic [31:0] M_DAT_O,
    output logic [2:0]  M_CTI_O,
    input  logic [31:0] M_DAT_I,
    input  logic        M_ACK,
    input  logic        M_ERR,
    input  logic        M_RTY
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_W   = 30 - OFF_W - IDX_W;
    localparam int IDX_LSB = OFF_W + 2;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam logic [OFF_W-1:0] c_LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:2]        r_adr;
    logic [31:0]        r_dat;
    logic               r_we;
    logic [OFF_W-1:0]   r_beat;
    logic               r_drop;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES][WORDS_PER_LINE];

    logic               r_s_ack;
    logic               r_s_err;
    logic               r_s_rty;
    logic [31:0]        r_s_dat;

    logic [IDX_W-1:0]   w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [OFF_W-1:0]   w_off;
    logic               w_req_hit;
    logic               w_line_hit;
    logic               w_bus_fault;
    logic               w_last;
    logic               w_resp_busy;
    logic               w_req;
    logic               w_report;
    logic               w_unused;

    assign w_req_idx   = S_ADR[TAG_LSB-1:IDX_LSB];
    assign w_req_tag   = S_ADR[31:TAG_LSB];
    assign w_idx       = r_adr[TAG_LSB-1:IDX_LSB];
    assign w_tag       = r_adr[31:TAG_LSB];
    assign w_off       = r_adr[IDX_LSB-1:2];
    assign w_req_hit   = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_line_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_bus_fault = M_ERR | M_RTY;
    assign w_last      = (r_beat == c_LAST_BEAT);
    // A response is still on the bus: a master holding STB must not re-trigger.
    assign w_resp_busy = r_s_ack | r_s_err | r_s_rty;
    assign w_req       = S_CYC & S_STB & ~w_resp_busy;
    assign w_report    = S_CYC & ~r_drop;
    assign w_unused    = ^{S_CTI_O, S_ADR[1:0]};

    assign S_ACK   = r_s_ack;
    assign S_ERR   = r_s_err;
    assign S_RTY   = r_s_rty;
    assign S_DAT_I = r_s_dat;

    always_comb begin
        w_state_nxt = r_state;
        M_CYC       = 1'b0;
        M_STB       = 1'b0;
        M_WE        = 1'b0;
        M_ADR       = '0;
        M_DAT_O     = '0;
        M_CTI_O     = 3'b000;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (S_WE)
                        w_state_nxt = ST_WRITE;
                    else if (w_req_hit)
                        w_state_nxt = ST_RESP;
                    else
                        w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                M_CYC   = 1'b1;
                M_STB   = 1'b1;
                M_ADR   = {r_adr[31:IDX_LSB], r_beat, 2'b00};
                M_CTI_O = w_last ? 3'b111 : 3'b010;
                if (w_bus_fault)
                    w_state_nxt = ST_IDLE;
                else if (M_ACK && w_last)
                    w_state_nxt = ST_RESP;
            end
            ST_WRITE: begin
                M_CYC   = 1'b1;
                M_STB   = 1'b1;
                M_WE    = 1'b1;
                M_ADR   = {r_adr, 2'b00};
                M_DAT_O = r_dat;
                if (w_bus_fault)
                    w_state_nxt = ST_IDLE;
                else if (M_ACK)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_adr   <= '0;
            r_dat   <= '0;
            r_we    <= 1'b0;
            r_beat  <= '0;
            r_drop  <= 1'b0;
            r_valid <= '0;
            r_s_ack <= 1'b0;
            r_s_err <= 1'b0;
            r_s_rty <= 1'b0;
            r_s_dat <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s_ack <= 1'b0;
            r_s_err <= 1'b0;
            r_s_rty <= 1'b0;
            r_s_dat <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_adr  <= S_ADR[31:2];
                        r_dat  <= S_DAT_O;
                        r_we   <= S_WE;
                        r_beat <= '0;
                        r_drop <= 1'b0;
                    end
                end
                ST_FILL, ST_WRITE: begin
                    // An abandoned CPU cycle still finishes on memory, silently.
                    if (!S_CYC)
                        r_drop <= 1'b1;
                    if (w_bus_fault) begin
                        r_valid[w_idx] <= 1'b0;
                        r_s_err        <= M_ERR & w_report;
                        r_s_rty        <= ~M_ERR & M_RTY & w_report;
                    end else if (M_ACK && (r_state == ST_FILL)) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last)
                            r_valid[w_idx] <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_s_ack <= w_report;
                    if (w_report && !r_we)
                        r_s_dat <= r_data[w_idx][w_off];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == ST_FILL) && M_ACK && !w_bus_fault) begin
            r_data[w_idx][r_beat] <= M_DAT_I;
            if (w_last)
                r_tag[w_idx] <= w_tag;
        end
        if ((r_state == ST_WRITE) && M_ACK && !w_bus_fault && w_line_hit)
            r_data[w_idx][w_off] <= r_dat;
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_cache.sv
// ============================================================================
// Module   : tb_wb_cache
// Purpose  : Directed self-checking bench for wb_cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        S_CYC, S_STB, S_WE;
    logic [31:0] S_ADR, S_DAT_O;
    logic [2:0]  S_CTI_O;
    logic [31:0] S_DAT_I;
    logic        S_ACK, S_ERR, S_RTY;
    logic        M_CYC, M_STB, M_WE;
    logic [31:0] M_ADR, M_DAT_O;
    logic [2:0]  M_CTI_O;
    logic [31:0] m_dat;
    logic        m_ack, m_err, m_rty;

    int n_cmp  = 0;
    int n_fail = 0;
    int err_beat = -1;
    int rty_beat = -1;
    int beat_cnt = 0;
    int nlog = 0;
    logic [31:0] log_adr [256];
    logic [31:0] log_dat [256];
    logic        log_we  [256];
    logic [2:0]  log_cti [256];

    always #5 clk = ~clk;

    wb_cache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .rst(rst),
        .S_CYC(S_CYC), .S_STB(S_STB), .S_WE(S_WE), .S_ADR(S_ADR),
        .S_DAT_O(S_DAT_O), .S_CTI_O(S_CTI_O), .S_DAT_I(S_DAT_I),
        .S_ACK(S_ACK), .S_ERR(S_ERR), .S_RTY(S_RTY),
        .M_CYC(M_CYC), .M_STB(M_STB), .M_WE(M_WE), .M_ADR(M_ADR),
        .M_DAT_O(M_DAT_O), .M_CTI_O(M_CTI_O), .M_DAT_I(m_dat),
        .M_ACK(m_ack), .M_ERR(m_err), .M_RTY(m_rty)
    );

    // Memory: one response per strobe, one cycle later; data = addr ^ A5A50000.
    always @(posedge clk) begin
        m_ack <= 1'b0;
        m_err <= 1'b0;
        m_rty <= 1'b0;
        if (!M_CYC) begin
            beat_cnt <= 0;
        end else if (M_STB && !m_ack && !m_err && !m_rty) begin
            if (nlog < 256) begin
                log_adr[nlog] <= M_ADR;
                log_dat[nlog] <= M_DAT_O;
                log_we[nlog]  <= M_WE;
                log_cti[nlog] <= M_CTI_O;
            end
            nlog <= nlog + 1;
            if (beat_cnt == err_beat)
                m_err <= 1'b1;
            else if (beat_cnt == rty_beat)
                m_rty <= 1'b1;
            else begin
                m_ack <= 1'b1;
                m_dat <= M_ADR ^ 32'hA5A50000;
            end
            beat_cnt <= beat_cnt + 1;
        end
    end

    task automatic cpu_req(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output int acks,
                           output int errs, output int rtys, output int beats);
        int  n0;
        logic seen;
        n0 = nlog; acks = 0; errs = 0; rtys = 0; lat = 0; rd = '0; seen = 1'b0;
        @(posedge clk); #1;
        S_CYC = 1'b1; S_STB = 1'b1; S_WE = we; S_ADR = adr; S_DAT_O = wd;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (S_ACK || S_ERR || S_RTY) begin
                seen = 1'b1;
                rd   = S_DAT_I;
                acks += S_ACK ? 1 : 0;
                errs += S_ERR ? 1 : 0;
                rtys += S_RTY ? 1 : 0;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout adr=%h: no response after %0d cycles, required one", adr, lat);
        end
        // Master keeps STB one extra cycle, then watches for stray responses.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            S_CYC = 1'b0; S_STB = 1'b0; S_WE = 1'b0;
            acks += S_ACK ? 1 : 0;
            errs += S_ERR ? 1 : 0;
            rtys += S_RTY ? 1 : 0;
        end
        beats = nlog - n0;
    endtask

    task automatic test_reset();
        rst = 1'b1; S_CYC = 0; S_STB = 0; S_WE = 0; S_ADR = '0; S_DAT_O = '0; S_CTI_O = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({S_ACK, S_ERR, S_RTY} !== 3'b000) begin n_fail++; $display("FAIL reset_s_resp got=%b want=000", {S_ACK, S_ERR, S_RTY}); end
        n_cmp++; if (S_DAT_I !== 32'h0) begin n_fail++; $display("FAIL reset_s_dat got=%h want=0", S_DAT_I); end
        n_cmp++; if ({M_CYC, M_STB, M_WE} !== 3'b000) begin n_fail++; $display("FAIL reset_m_ctl got=%b want=000", {M_CYC, M_STB, M_WE}); end
        n_cmp++; if ({M_ADR, M_DAT_O, M_CTI_O} !== 67'h0) begin n_fail++; $display("FAIL reset_m_bus got=%h/%h/%b want=0", M_ADR, M_DAT_O, M_CTI_O); end
        rst = 1'b0;
    endtask

    task automatic test_read_miss();
        logic [31:0] rd; int lat, acks, errs, rtys, beats, n0;
        n0 = nlog;
        cpu_req(1'b0, 32'h1404, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (rd !== 32'hA5A51404) begin n_fail++; $display("FAIL miss_data got=%h want=a5a51404", rd); end
        n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL miss_latency got=%0d want=10", lat); end
        n_cmp++; if (beats !== 4) begin n_fail++; $display("FAIL miss_beats got=%0d want=4", beats); end
        n_cmp++; if ({acks, errs, rtys} !== {32'd1, 32'd0, 32'd0}) begin n_fail++; $display("FAIL miss_resp got=%0d/%0d/%0d want=1/0/0", acks, errs, rtys); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (log_adr[n0+i] !== 32'h1400 + 32'(4*i) || log_cti[n0+i] !== ((i < 3) ? 3'b010 : 3'b111) || log_we[n0+i] !== 1'b0) begin
                n_fail++;
                $display("FAIL miss_beat%0d got adr=%h cti=%b we=%b want adr=%h", i, log_adr[n0+i], log_cti[n0+i], log_we[n0+i], 32'h1400 + 32'(4*i));
            end
        end
    endtask

    task automatic test_read_hit();
        logic [31:0] rd; int lat, acks, errs, rtys, beats;
        cpu_req(1'b0, 32'h1408, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (rd !== 32'hA5A51408) begin n_fail++; $display("FAIL hit_data got=%h want=a5a51408", rd); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL hit_latency got=%0d want=2", lat); end
        n_cmp++; if (beats !== 0) begin n_fail++; $display("FAIL hit_mem_access got=%0d want=0", beats); end
        n_cmp++; if (acks !== 1) begin n_fail++; $display("FAIL hit_single_ack got=%0d want=1", acks); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int lat, acks, errs, rtys, beats, n0;
        n0 = nlog;
        cpu_req(1'b1, 32'h1408, 32'hDEADBEEF, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 1) begin n_fail++; $display("FAIL wr_beats got=%0d want=1", beats); end
        n_cmp++;
        if (log_adr[n0] !== 32'h1408 || log_dat[n0] !== 32'hDEADBEEF || log_we[n0] !== 1'b1 || log_cti[n0] !== 3'b000) begin
            n_fail++;
            $display("FAIL wr_bus got adr=%h dat=%h we=%b cti=%b want 1408/deadbeef/1/000", log_adr[n0], log_dat[n0], log_we[n0], log_cti[n0]);
        end
        n_cmp++; if (acks !== 1 || lat !== 4) begin n_fail++; $display("FAIL wr_ack got acks=%0d lat=%0d want 1/4", acks, lat); end
        cpu_req(1'b0, 32'h1408, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_reread got=%h want=deadbeef", rd); end
        n_cmp++; if (beats !== 0) begin n_fail++; $display("FAIL wr_reread_access got=%0d want=0", beats); end
    endtask

    task automatic test_conflict();
        logic [31:0] rd; int lat, acks, errs, rtys, beats;
        cpu_req(1'b0, 32'h1400, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 0 || rd !== 32'hA5A51400) begin n_fail++; $display("FAIL conf_first got beats=%0d data=%h want 0/a5a51400", beats, rd); end
        cpu_req(1'b0, 32'h1500, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 4 || rd !== 32'hA5A51500) begin n_fail++; $display("FAIL conf_evict got beats=%0d data=%h want 4/a5a51500", beats, rd); end
        cpu_req(1'b0, 32'h1400, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 4 || rd !== 32'hA5A51400) begin n_fail++; $display("FAIL conf_refill got beats=%0d data=%h want 4/a5a51400", beats, rd); end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd; int lat, acks, errs, rtys, beats;
        cpu_req(1'b1, 32'h2000, 32'h12345678, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 1 || acks !== 1) begin n_fail++; $display("FAIL wmiss_write got beats=%0d acks=%0d want 1/1", beats, acks); end
        cpu_req(1'b0, 32'h2000, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 4 || rd !== 32'hA5A52000) begin n_fail++; $display("FAIL wmiss_read got beats=%0d data=%h want 4/a5a52000", beats, rd); end
    endtask

    task automatic test_error();
        logic [31:0] rd; int lat, acks, errs, rtys, beats;
        err_beat = 2;
        cpu_req(1'b0, 32'h3004, 32'h0, rd, lat, acks, errs, rtys, beats);
        err_beat = -1;
        n_cmp++; if ({acks, errs, rtys} !== {32'd0, 32'd1, 32'd0}) begin n_fail++; $display("FAIL err_resp got=%0d/%0d/%0d want=0/1/0", acks, errs, rtys); end
        n_cmp++; if (beats !== 3) begin n_fail++; $display("FAIL err_beats got=%0d want=3", beats); end
        cpu_req(1'b0, 32'h3004, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 4 || rd !== 32'hA5A53004 || acks !== 1) begin n_fail++; $display("FAIL err_refill got beats=%0d data=%h acks=%0d want 4/a5a53004/1", beats, rd, acks); end
    endtask

    task automatic test_retry();
        logic [31:0] rd; int lat, acks, errs, rtys, beats;
        rty_beat = 0;
        cpu_req(1'b1, 32'h3008, 32'hCAFEF00D, rd, lat, acks, errs, rtys, beats);
        rty_beat = -1;
        n_cmp++; if ({acks, errs, rtys} !== {32'd0, 32'd0, 32'd1}) begin n_fail++; $display("FAIL rty_resp got=%0d/%0d/%0d want=0/0/1", acks, errs, rtys); end
        // The retried write invalidated the line, so this must refill.
        cpu_req(1'b0, 32'h3008, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 4 || rd !== 32'hA5A53008) begin n_fail++; $display("FAIL rty_refill got beats=%0d data=%h want 4/a5a53008", beats, rd); end
    endtask

    task automatic test_cyc_drop();
        logic [31:0] rd; int lat, acks, errs, rtys, beats, n0, stray;
        n0 = nlog; stray = 0;
        @(posedge clk); #1;
        S_CYC = 1'b1; S_STB = 1'b1; S_WE = 1'b0; S_ADR = 32'h6000;
        repeat (2) @(posedge clk);
        #1;
        S_CYC = 1'b0; S_STB = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            stray += (S_ACK || S_ERR || S_RTY) ? 1 : 0;
        end
        n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL drop_suppress got=%0d want=0", stray); end
        n_cmp++; if (nlog - n0 !== 4) begin n_fail++; $display("FAIL drop_fill_beats got=%0d want=4", nlog - n0); end
        cpu_req(1'b0, 32'h6008, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 0 || rd !== 32'hA5A56008) begin n_fail++; $display("FAIL drop_hit got beats=%0d data=%h want 0/a5a56008", beats, rd); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd; int lat, acks, errs, rtys, beats;
        cpu_req(1'b0, 32'h1404, 32'h0, rd, lat, acks, errs, rtys, beats);
        cpu_req(1'b0, 32'h1404, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 0) begin n_fail++; $display("FAIL rstfill_precached got=%0d want=0", beats); end
        @(posedge clk); #1;
        S_CYC = 1'b1; S_STB = 1'b1; S_WE = 1'b0; S_ADR = 32'h5040;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (M_CYC !== 1'b1) begin n_fail++; $display("FAIL rstfill_active got=%b want=1", M_CYC); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({M_CYC, M_STB, M_CTI_O} !== 5'b0 || M_ADR !== 32'h0) begin n_fail++; $display("FAIL rstfill_outputs got cyc=%b stb=%b adr=%h want 0", M_CYC, M_STB, M_ADR); end
        S_CYC = 1'b0; S_STB = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_req(1'b0, 32'h1404, 32'h0, rd, lat, acks, errs, rtys, beats);
        n_cmp++; if (beats !== 4 || rd !== 32'hA5A51404) begin n_fail++; $display("FAIL rstfill_miss got beats=%0d data=%h want 4/a5a51404", beats, rd); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_conflict();
        test_write_miss();
        test_error();
        test_retry();
        test_cyc_drop();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
